pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed MEM/WB pipeline register; a generic inter-stage buffer for any pipeline boundary (IF/ID through MEM/WB).
- Adds a per-entry valid bit, a valid/ready handshake, a 1-entry skid buffer so that inReady is a registered signal, and flush (bubble insertion).
- Adds a forwarding tap so the hazard unit can bypass from this stage without extra decode.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_entry.sv | 34 +++
 rtl/pipe_stage_buf.sv | 118 +++++++++++
 tb/tb_pipe_stage_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: default widths, the
// zero-register index and the packed control bits carried with each entry.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  // Writes to this register index are discarded, so it is never forwarded.
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic reg_write;
    logic mem2reg;
  } ctrl_t;

  function automatic ctrl_t pack_ctrl(input logic reg_write, input logic mem2reg);
    ctrl_t c;
    c.reg_write = reg_write;
    c.mem2reg   = mem2reg;
    return c;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One buffer slot: a valid bit plus an opaque payload. Clear wins over load;
// with neither asserted the slot holds.
module pipe_entry #(
  parameter int unsigned W = 1
) (
  input  logic         clockIn,
  input  logic         resetN,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic         valid_q;
  logic [W-1:0] pay_q;

  // Slot state: clear invalidates, load captures a new entry.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pay_q   <= din;
    end
  end

  assign valid = valid_q;
  assign dout  = pay_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline buffer: main (head) slot plus a one-entry skid
// slot so that inReady comes straight from a flop. Also exposes a forwarding
// tap for the hazard unit.
module pipe_stage_buf #(
  parameter int unsigned DATA_W     = pipe_pkg::DATA_W,
  parameter int unsigned NUM_DATA   = 2,
  parameter int unsigned REG_W      = pipe_pkg::REG_W,
  parameter int unsigned FWD_MEM_CH = 1
) (
  input  logic                       clockIn,
  input  logic                       resetN,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic                       regWriteIn,
  input  logic                       mem2RegIn,
  input  logic [NUM_DATA*DATA_W-1:0] dataIn,
  input  logic [REG_W-1:0]           regIn,
  output logic                       outValid,
  input  logic                       outReady,
  output logic                       regWriteOut,
  output logic                       mem2RegOut,
  output logic [NUM_DATA*DATA_W-1:0] dataOut,
  output logic [REG_W-1:0]           regOut,
  output logic                       fwdEn,
  output logic [REG_W-1:0]           fwdReg,
  output logic [DATA_W-1:0]          fwdData,
  output logic [1:0]                 occupancy
);

  import pipe_pkg::*;

  localparam int unsigned PAY_W = 2 + NUM_DATA * DATA_W + REG_W;

  logic             main_v, skid_v;
  logic [PAY_W-1:0] main_pay, skid_pay, in_pay, main_din;
  logic             main_load, main_clear, skid_load, skid_clear;
  logic             main_from_skid;
  logic             accept, emit;
  logic             in_ready_q, in_ready_d;
  ctrl_t            main_ctrl;

  assign in_pay = {pack_ctrl(regWriteIn, mem2RegIn), dataIn, regIn};

  assign accept = inValid & in_ready_q & ~stall;
  assign emit   = main_v & outReady & ~stall;

  // Slot controls. accept implies the skid is empty (inReady mirrors it), and
  // stall forces accept/emit low so every slot holds. Flush clears both.
  always_comb begin
    main_from_skid = emit & skid_v;
    main_load      = ~flush & (main_from_skid | (accept & (~main_v | emit)));
    main_clear     = flush | (emit & ~skid_v & ~accept);
    skid_load      = ~flush & accept & main_v & ~emit;
    skid_clear     = flush | main_from_skid;
    main_din       = main_from_skid ? skid_pay : in_pay;
  end

  pipe_entry #(
    .W (PAY_W)
  ) u_main (
    .clockIn (clockIn),
    .resetN  (resetN),
    .load    (main_load),
    .clear   (main_clear),
    .din     (main_din),
    .valid   (main_v),
    .dout    (main_pay)
  );

  pipe_entry #(
    .W (PAY_W)
  ) u_skid (
    .clockIn (clockIn),
    .resetN  (resetN),
    .load    (skid_load),
    .clear   (skid_clear),
    .din     (in_pay),
    .valid   (skid_v),
    .dout    (skid_pay)
  );

  // inReady tracks the next skid state so it can be a plain flop output.
  always_comb begin
    in_ready_d = in_ready_q;
    if (skid_clear) begin
      in_ready_d = 1'b1;
    end else if (skid_load) begin
      in_ready_d = 1'b0;
    end
  end

  // Ready flop; resets to 1 because an empty buffer can always accept.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  assign {main_ctrl, dataOut, regOut} = main_pay;

  assign inReady     = in_ready_q;
  assign outValid    = main_v;
  assign regWriteOut = main_v & main_ctrl.reg_write;
  assign mem2RegOut  = main_ctrl.mem2reg;
  assign occupancy   = {1'b0, main_v} + {1'b0, skid_v};

  // Forwarding tap: loads forward the memory channel, everything else ch0.
  always_comb begin
    fwdEn   = regWriteOut & (regOut != REG_W'(REG_ZERO));
    fwdReg  = regOut;
    fwdData = mem2RegOut ? dataOut[FWD_MEM_CH*DATA_W +: DATA_W] : dataOut[DATA_W-1:0];
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  logic        clockIn = 1'b0;
  logic        resetN;
  logic        flush, stall, inValid, inReady;
  logic        regWriteIn, mem2RegIn;
  logic [63:0] dataIn;
  logic [4:0]  regIn;
  logic        outValid, outReady, regWriteOut, mem2RegOut;
  logic [63:0] dataOut;
  logic [4:0]  regOut;
  logic        fwdEn;
  logic [4:0]  fwdReg;
  logic [31:0] fwdData;
  logic [1:0]  occupancy;

  always #5 clockIn = ~clockIn;

  pipe_stage_buf #(
    .DATA_W     (32),
    .NUM_DATA   (2),
    .REG_W      (5),
    .FWD_MEM_CH (1)
  ) dut (
    .clockIn     (clockIn),
    .resetN      (resetN),
    .flush       (flush),
    .stall       (stall),
    .inValid     (inValid),
    .inReady     (inReady),
    .regWriteIn  (regWriteIn),
    .mem2RegIn   (mem2RegIn),
    .dataIn      (dataIn),
    .regIn       (regIn),
    .outValid    (outValid),
    .outReady    (outReady),
    .regWriteOut (regWriteOut),
    .mem2RegOut  (mem2RegOut),
    .dataOut     (dataOut),
    .regOut      (regOut),
    .fwdEn       (fwdEn),
    .fwdReg      (fwdReg),
    .fwdData     (fwdData),
    .occupancy   (occupancy)
  );

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  rg;
  } ent_t;

  typedef struct {
    logic        iv, ordy, st, fl, rw, m2r;
    logic [31:0] d0, d1;
    logic [4:0]  rg;
    logic        e_ov;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic [31:0] e_d0;
  } vec_t;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the scoreboard head.
  task automatic compare_sb();
    ent_t e;
    chk("outValid", 64'(outValid), 64'(sb.size() > 0));
    chk("occupancy", 64'(occupancy), 64'(sb.size()));
    chk("inReady", 64'(inReady), 64'(sb.size() < 2));
    if (sb.size() > 0) begin
      e = sb[0];
      chk("regWriteOut", 64'(regWriteOut), 64'(e.rw));
      chk("mem2RegOut", 64'(mem2RegOut), 64'(e.m2r));
      chk("dataOut_ch0", 64'(dataOut[31:0]), 64'(e.d0));
      chk("dataOut_ch1", 64'(dataOut[63:32]), 64'(e.d1));
      chk("regOut", 64'(regOut), 64'(e.rg));
      chk("fwdEn", 64'(fwdEn), 64'(e.rw && (e.rg != 5'd0)));
      chk("fwdReg", 64'(fwdReg), 64'(e.rg));
      chk("fwdData", 64'(fwdData), 64'(e.m2r ? e.d1 : e.d0));
    end else begin
      chk("regWriteOut_idle", 64'(regWriteOut), 64'(0));
      chk("fwdEn_idle", 64'(fwdEn), 64'(0));
    end
  endtask

  // Drive one cycle of stimulus, advance the reference FIFO, check at negedge.
  task automatic step(input vec_t v);
    ent_t e;
    bit   acc, emt;
    inValid    = v.iv;
    outReady   = v.ordy;
    stall      = v.st;
    flush      = v.fl;
    regWriteIn = v.rw;
    mem2RegIn  = v.m2r;
    dataIn     = {v.d1, v.d0};
    regIn      = v.rg;
    e.rw = v.rw; e.m2r = v.m2r; e.d0 = v.d0; e.d1 = v.d1; e.rg = v.rg;
    if (v.fl) begin
      sb.delete();
    end else if (!v.st) begin
      emt = (sb.size() > 0) && v.ordy;
      acc = v.iv && (sb.size() < 2);
      if (emt) void'(sb.pop_front());
      if (acc) sb.push_back(e);
    end
    @(posedge clockIn);
    @(negedge clockIn);
    compare_sb();
  endtask

  function automatic vec_t mk(input logic [5:0] ctl, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [4:0] rg, input logic [3:0] ex, input logic [31:0] ed0);
    vec_t v;
    {v.iv, v.ordy, v.st, v.fl, v.rw, v.m2r} = ctl;
    v.d0 = d0; v.d1 = d1; v.rg = rg;
    {v.e_ov, v.e_occ, v.e_ir} = ex;
    v.e_d0 = ed0;
    return v;
  endfunction

  initial begin
    vec_t v;
    // ctl = {inValid, outReady, stall, flush, regWrite, mem2Reg}; ex = {ov, occ[1:0], ir}
    tbl[0]  = mk(6'b110010, 32'h11,  32'h0,   5'd1, 4'b1011, 32'h11);   // streaming
    tbl[1]  = mk(6'b110011, 32'h22,  32'h23,  5'd2, 4'b1011, 32'h22);
    tbl[2]  = mk(6'b110000, 32'h33,  32'h34,  5'd3, 4'b1011, 32'h33);
    tbl[3]  = mk(6'b010000, 32'h0,   32'h0,   5'd0, 4'b0001, 32'h0);
    tbl[4]  = mk(6'b100010, 32'hA,   32'hA1,  5'd4, 4'b1011, 32'hA);    // skid fill
    tbl[5]  = mk(6'b100010, 32'hB,   32'hB1,  5'd6, 4'b1100, 32'hA);
    tbl[6]  = mk(6'b100010, 32'hC,   32'h0,   5'd7, 4'b1100, 32'hA);    // refused
    tbl[7]  = mk(6'b010000, 32'h0,   32'h0,   5'd0, 4'b1011, 32'hB);
    tbl[8]  = mk(6'b010000, 32'h0,   32'h0,   5'd0, 4'b0001, 32'h0);
    tbl[9]  = mk(6'b100010, 32'h51,  32'h0,   5'd1, 4'b1011, 32'h51);   // flush
    tbl[10] = mk(6'b100010, 32'h52,  32'h0,   5'd2, 4'b1100, 32'h51);
    tbl[11] = mk(6'b101110, 32'h53,  32'h0,   5'd3, 4'b0001, 32'h0);
    tbl[12] = mk(6'b010000, 32'h0,   32'h0,   5'd0, 4'b0001, 32'h0);
    tbl[13] = mk(6'b100011, 32'h100, 32'h200, 5'd5, 4'b1011, 32'h100);  // forwarding
    tbl[14] = mk(6'b010000, 32'h0,   32'h0,   5'd0, 4'b0001, 32'h0);
    tbl[15] = mk(6'b100011, 32'h100, 32'h200, 5'd0, 4'b1011, 32'h100);
    tbl[16] = mk(6'b010000, 32'h0,   32'h0,   5'd0, 4'b0001, 32'h0);
    tbl[17] = mk(6'b110010, 32'h7,   32'h8,   5'd7, 4'b1011, 32'h7);
    tbl[18] = mk(6'b111010, 32'h61,  32'h62,  5'd9, 4'b1011, 32'h7);    // stall hold
    tbl[19] = mk(6'b111010, 32'h61,  32'h62,  5'd9, 4'b1011, 32'h7);
    tbl[20] = mk(6'b111010, 32'h61,  32'h62,  5'd9, 4'b1011, 32'h7);
    tbl[21] = mk(6'b110010, 32'h61,  32'h62,  5'd9, 4'b1011, 32'h61);
    tbl[22] = mk(6'b010000, 32'h0,   32'h0,   5'd0, 4'b0001, 32'h0);

    resetN = 1'b0;
    {flush, stall, inValid, outReady, regWriteIn, mem2RegIn} = '0;
    dataIn = '0;
    regIn  = '0;
    repeat (2) @(negedge clockIn);
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_inReady", 64'(inReady), 64'(1));
    resetN = 1'b1;
    compare_sb();

    for (int i = 0; i < 23; i++) begin
      step(tbl[i]);
      chk($sformatf("tbl%0d_outValid", i), 64'(outValid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_inReady", i), 64'(inReady), 64'(tbl[i].e_ir));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_ch0", i), 64'(dataOut[31:0]), 64'(tbl[i].e_d0));
    end

    // Randomised traffic with occasional stall and flush, scoreboard checked.
    for (int i = 0; i < 60; i++) begin
      v.iv   = ($urandom_range(3) != 0);
      v.ordy = ($urandom_range(2) != 0);
      v.st   = ($urandom_range(7) == 0);
      v.fl   = ($urandom_range(15) == 0);
      v.rw   = $urandom_range(1) == 1;
      v.m2r  = $urandom_range(1) == 1;
      v.d0   = $urandom;
      v.d1   = $urandom;
      v.rg   = 5'($urandom_range(31));
      step(v);
    end

    // Asynchronous reset with both slots full: outputs clear before any edge.
    step(mk(6'b100010, 32'hE1, 32'hE2, 5'd3, 4'b0000, 32'h0));
    step(mk(6'b100010, 32'hF1, 32'hF2, 5'd4, 4'b0000, 32'h0));
    chk("prerst_occupancy", 64'(occupancy), 64'(2));
    #2;
    resetN = 1'b0;
    #1;
    chk("arst_outValid", 64'(outValid), 64'(0));
    chk("arst_regWriteOut", 64'(regWriteOut), 64'(0));
    chk("arst_occupancy", 64'(occupancy), 64'(0));
    chk("arst_inReady", 64'(inReady), 64'(1));
    chk("arst_fwdEn", 64'(fwdEn), 64'(0));
    chk("arst_dataOut", dataOut, 64'(0));
    sb.delete();
    inValid = 1'b0;
    @(posedge clockIn);
    @(negedge clockIn);
    resetN = 1'b1;
    compare_sb();
    step(mk(6'b110010, 32'h99, 32'h98, 5'd8, 4'b1011, 32'h99));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
